// File: rtl/booth_div.sv
// Sequential signed divider: 2*width-bit dividend by width-bit divisor, radix-2
// restoring on magnitudes with a sign/overflow fix-up cycle.
module booth_div #(
    parameter int unsigned width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic [2*width-1:0]   N,
    input  logic [width-1:0]     D,
    output logic                 busy,
    output logic                 done,
    output logic [width-1:0]     Q,
    output logic [width-1:0]     R,
    output logic                 dz,
    output logic                 ovf
);

    localparam int unsigned W2 = 2 * width;
    localparam int unsigned CW = $clog2(width + 1);
    localparam logic [width-1:0] MAX_POS = {1'b0, {(width-1){1'b1}}};
    localparam logic [width-1:0] MAX_NEG = {1'b1, {(width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [W2-1:0]     pr;
    logic [width-1:0]  dmag;
    logic              qs;
    logic              rs;
    logic              po;
    logic              z;

    logic [W2:0]       n_ext;
    logic [W2:0]       n_mag;
    logic [width:0]    d_ext;
    logic [width:0]    d_mag;
    logic [width:0]    hi_sh;
    logic [width-1:0]  diff;
    logic              fits;
    logic [W2-1:0]     pr_nxt;
    logic [width-1:0]  qmag;
    logic [width-1:0]  rmag;
    logic              q_ovf;

    assign busy = (state == CALC) || (state == FIX);

    // Operand magnitudes; one extra bit keeps |most negative| exact.
    always_comb begin
        n_ext = {N[W2-1], N};
        n_mag = N[W2-1] ? (W2+1)'(-n_ext) : n_ext;
        d_ext = {D[width-1], D};
        d_mag = D[width-1] ? (width+1)'(-d_ext) : d_ext;
    end

    // One restoring step: shift left, trial-subtract |D| from the top width+1 bits.
    always_comb begin
        hi_sh  = pr[W2-1:width-1];
        fits   = (hi_sh >= {1'b0, dmag});
        diff   = pr[W2-2:width-1] - dmag;
        pr_nxt = {(fits ? diff : pr[W2-2:width-1]), pr[width-2:0], fits};
    end

    // After width steps the low half is the quotient magnitude, the high half the remainder.
    always_comb begin
        qmag  = pr[width-1:0];
        rmag  = pr[W2-1:width];
        q_ovf = po || (!qs && (qmag > MAX_POS)) || (qs && (qmag > MAX_NEG));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pr    <= '0;
            dmag  <= '0;
            qs    <= 1'b0;
            rs    <= 1'b0;
            po    <= 1'b0;
            z     <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pr    <= n_mag[W2-1:0];
                        dmag  <= d_mag[width-1:0];
                        qs    <= N[W2-1] ^ D[width-1];
                        rs    <= N[W2-1];
                        po    <= (n_mag[W2:width] >= d_mag);
                        z     <= (D == '0);
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    pr  <= pr_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(width - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (z) begin
                        dz  <= 1'b1;
                        ovf <= 1'b0;
                        Q   <= '0;
                        R   <= '0;
                    end else if (q_ovf) begin
                        dz  <= 1'b0;
                        ovf <= 1'b1;
                        Q   <= '0;
                        R   <= '0;
                    end else begin
                        dz  <= 1'b0;
                        ovf <= 1'b0;
                        Q   <= qs ? width'(-qmag) : qmag;
                        R   <= rs ? width'(-rmag) : rmag;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div.sv
// Scoreboard bench for booth_div: directed vectors, freeze/abort/ignore cases, random sweep.
`timescale 1ns/1ps
module tb_booth_div;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           start;
    logic [2*W-1:0] N;
    logic [W-1:0]   D;
    logic           busy;
    logic           done;
    logic [W-1:0]   Q;
    logic [W-1:0]   R;
    logic           dz;
    logic           ovf;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           due;
        int           extra;
    } exp_t;

    typedef struct {
        int n;
        int d;
        int q;
        int r;
        int dz;
        int ovf;
    } vec_t;

    exp_t sb[$];
    vec_t dv[14];
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   ncyc     = 0;
    int   busy_run = 0;

    booth_div #(.width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
        .N     (N),
        .D     (D),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic exp_t model(input logic [2*W-1:0] n, input logic [W-1:0] d);
        exp_t e;
        int ni, di, q, r;
        e.q = '0; e.r = '0; e.dz = 1'b0; e.ovf = 1'b0; e.due = 0; e.extra = 0;
        ni = int'($signed(n));
        di = int'($signed(d));
        if (di == 0) begin
            e.dz = 1'b1;
        end else begin
            q = ni / di;
            r = ni % di;
            if (q > (2**(W-1) - 1) || q < -(2**(W-1))) begin
                e.ovf = 1'b1;
            end else begin
                e.q = W'(q);
                e.r = W'(r);
            end
        end
        return e;
    endfunction

    // Drive one start pulse from between edges; due is the negedge index where done must show.
    task automatic issue(input logic [2*W-1:0] n, input logic [W-1:0] d, input exp_t e,
                         input int extra, input bit push);
        exp_t x;
        x = e;
        N = n;
        D = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        x.due   = ncyc + int'(W) + 2 + extra;
        x.extra = extra;
        if (push) sb.push_back(x);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: got no done within 60 cycles, expected done");
        end
    endtask

    // Monitor: pops the scoreboard on every done cycle and checks result, latency and busy length.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", ncyc);
                end else begin
                    e = sb.pop_front();
                    check("Q", $signed(Q), $signed(e.q));
                    check("R", $signed(R), $signed(e.r));
                    check("dz", 32'(dz), 32'(e.dz));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("done_cycle", ncyc, e.due);
                    check("busy_len", busy_run, int'(W) + 1 + e.extra);
                end
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        exp_t none;
        int   di, qi, ri;
        logic [2*W-1:0] rn;
        logic [W-1:0]   rd;

        dv = '{
            '{-100,     7,  -14,  -2, 0, 0},
            '{ 300,    -3, -100,   0, 0, 0},
            '{  -1,     2,    0,  -1, 0, 0},
            '{16129,  127,  127,   0, 0, 0},
            '{1234,     0,    0,   0, 1, 0},
            '{-32768,  -1,    0,   0, 0, 1},
            '{ 128,     1,    0,   0, 0, 1},
            '{-128,     1, -128,   0, 0, 0},
            '{32767, -128,    0,   0, 0, 1},
            '{-16384,-128,    0,   0, 0, 1},
            '{16384, -128, -128,   0, 0, 0},
            '{1000,    33,   30,  10, 0, 0},
            '{-1000,  -33,   30, -10, 0, 0},
            '{   0,    -5,    0,   0, 0, 0}
        };
        none.q = '0; none.r = '0; none.dz = 1'b0; none.ovf = 1'b0; none.due = 0; none.extra = 0;

        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        N     = '0;
        D     = '0;
        @(negedge clk);
        check("rst_Q", $signed(Q), 0);
        check("rst_R", $signed(R), 0);
        check("rst_dz", 32'(dz), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, each start issued in the previous done cycle.
        foreach (dv[i]) begin
            e.q = W'(dv[i].q); e.r = W'(dv[i].r);
            e.dz = dv[i].dz[0]; e.ovf = dv[i].ovf[0]; e.due = 0; e.extra = 0;
            issue((2*W)'(dv[i].n), W'(dv[i].d), e, 0, 1'b1);
            wait_done();
        end

        // Leave nonzero outputs, then abort an operation with an asynchronous reset.
        e = none; e.q = W'(30); e.r = W'(10);
        issue((2*W)'(1000), W'(33), e, 0, 1'b1);
        wait_done();
        issue((2*W)'(-100), W'(7), none, 0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_Q", $signed(Q), 0);
        check("abort_R", $signed(R), 0);
        check("abort_dz", 32'(dz), 0);
        check("abort_ovf", 32'(ovf), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);

        // Freeze for 5 edges mid-CALC: done moves out by exactly 5 cycles.
        e = none; e.q = W'(-14); e.r = W'(-2);
        issue((2*W)'(-100), W'(7), e, 5, 1'b1);
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        wait_done();

        // A start (with new operands) while busy must not disturb the running op.
        e = none; e.q = W'(-100); e.r = W'(0);
        issue((2*W)'(300), W'(-3), e, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1 begin start = 1'b1; N = (2*W)'(1); D = W'(1); end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Random sweep, back-to-back, mostly near the representable quotient range.
        for (int k = 0; k < 1500; k++) begin
            rd = W'($urandom);
            if ($urandom_range(0, 15) == 0) rd = '0;
            if ($urandom_range(0, 3) == 0) begin
                rn = (2*W)'($urandom);
            end else begin
                di = int'($signed(rd));
                qi = int'($urandom_range(0, 260)) - 130;
                ri = int'($urandom_range(0, 255)) - 128;
                rn = (2*W)'(di * qi + ri);
            end
            issue(rn, rd, model(rn, rd), 0, 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
